// File: rtl/launchpad_pkg.sv
// Shared types and helpers for the 4x4 launchpad keypad scanner.
package launchpad_pkg;

  localparam int unsigned NUM_ROWS = 4;
  localparam int unsigned NUM_COLS = 4;

  typedef enum logic [1:0] {IDLE, DEB_PRESS, PRESSED, DEB_RELEASE} state_e;
  typedef enum logic [1:0] {NONE, SINGLE, MULTI} scan_e;

  // Number of active-low (pressed) bits in one column sample.
  function automatic logic [2:0] count_low(input logic [NUM_ROWS-1:0] rows);
    count_low = '0;
    for (int unsigned i = 0; i < NUM_ROWS; i++) begin
      count_low = count_low + {2'b00, ~rows[i]};
    end
  endfunction

  // Index of the lowest-numbered low row bit.
  function automatic logic [1:0] first_low(input logic [NUM_ROWS-1:0] rows);
    first_low = '0;
    for (int unsigned i = NUM_ROWS; i > 0; i--) begin
      if (!rows[i-1]) first_low = 2'(i - 1);
    end
  endfunction

endpackage

// File: rtl/keypad_decode.sv
// Grid position {y,x} to hex key code for the launchpad keypad.
module keypad_decode
  import launchpad_pkg::*;
(
  input  logic [3:0] i_yx,
  output logic [3:0] o_hex
);

  always_comb begin
    o_hex = 4'h0;
    unique case (i_yx)
      4'd0:  o_hex = 4'h1;
      4'd1:  o_hex = 4'h2;
      4'd2:  o_hex = 4'h3;
      4'd3:  o_hex = 4'hA;
      4'd4:  o_hex = 4'h4;
      4'd5:  o_hex = 4'h5;
      4'd6:  o_hex = 4'h6;
      4'd7:  o_hex = 4'hB;
      4'd8:  o_hex = 4'h7;
      4'd9:  o_hex = 4'h8;
      4'd10: o_hex = 4'h9;
      4'd11: o_hex = 4'hC;
      4'd12: o_hex = 4'h0;
      4'd13: o_hex = 4'hF;
      4'd14: o_hex = 4'hE;
      4'd15: o_hex = 4'hD;
      default: o_hex = 4'h0;
    endcase
  end

endmodule

// File: rtl/launchpad_scanner.sv
// Column-scanning keypad controller: synchronizes rows, classifies each
// 4-column frame and debounces presses/releases into key events.
module launchpad_scanner
  import launchpad_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 1000,
  parameter int unsigned DEBOUNCE = 4
) (
  input  logic       clk,
  input  logic       reset,
  output logic [3:0] col_drive,
  input  logic [3:0] row_in,
  output logic       key_valid,
  output logic [3:0] key_val,
  output logic       key_down
);

  localparam int unsigned DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned CW = $clog2(DEBOUNCE + 1);

  logic [3:0]    r_sync1, r_sync2;
  logic [DW-1:0] r_dwell;
  logic [1:0]    r_col;
  logic [1:0]    r_nlow;
  logic [3:0]    r_pos;
  state_e        r_state;
  logic [CW-1:0] r_cnt;
  logic [3:0]    r_cand;
  logic          r_key_valid;
  logic [3:0]    r_key_val;
  logic          r_key_down;

  logic          w_sample, w_frame_end, w_cnt_done;
  logic [2:0]    w_col_low, w_total;
  logic [1:0]    w_base, w_nlow_nxt;
  logic [3:0]    w_pos_nxt, w_dec_in, w_dec_val;
  logic [CW-1:0] w_cnt_inc;
  scan_e         w_scan;

  always_comb begin
    col_drive        = '1;
    col_drive[r_col] = 1'b0;
  end

  assign key_valid = r_key_valid;
  assign key_val   = r_key_val;
  assign key_down  = r_key_down;

  assign w_sample    = (r_dwell == DW'(SCAN_DIV - 1));
  assign w_frame_end = w_sample && (r_col == 2'd3);

  // Frame accumulator: column 0 starts a fresh count, saturating at 2 (MULTI).
  assign w_col_low  = count_low(r_sync2);
  assign w_base     = (r_col == 2'd0) ? 2'd0 : r_nlow;
  assign w_total    = {1'b0, w_base} + w_col_low;
  assign w_nlow_nxt = (w_total >= 3'd2) ? 2'd2 : w_total[1:0];
  assign w_pos_nxt  = (w_base == 2'd0 && w_col_low == 3'd1) ?
                      {first_low(r_sync2), r_col} : r_pos;

  always_comb begin
    w_scan = MULTI;
    if (w_total == 3'd0)      w_scan = NONE;
    else if (w_total == 3'd1) w_scan = SINGLE;
  end

  assign w_cnt_inc  = r_cnt + 1'b1;
  assign w_cnt_done = (w_cnt_inc == CW'(DEBOUNCE));

  // In IDLE the candidate is being loaded this edge, so decode the new key
  // directly; in DEB_PRESS an accept only happens when it equals r_cand.
  assign w_dec_in = (r_state == IDLE) ? w_pos_nxt : r_cand;

  keypad_decode u_decode (
    .i_yx  (w_dec_in),
    .o_hex (w_dec_val)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1     <= '1;
      r_sync2     <= '1;
      r_dwell     <= '0;
      r_col       <= '0;
      r_nlow      <= '0;
      r_pos       <= '0;
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_cand      <= '0;
      r_key_valid <= 1'b0;
      r_key_val   <= '0;
      r_key_down  <= 1'b0;
    end else begin
      r_sync1     <= row_in;
      r_sync2     <= r_sync1;
      r_key_valid <= 1'b0;

      if (w_sample) begin
        r_dwell <= '0;
        r_col   <= r_col + 1'b1;
        r_nlow  <= w_nlow_nxt;
        r_pos   <= w_pos_nxt;
      end else begin
        r_dwell <= r_dwell + 1'b1;
      end

      if (w_frame_end) begin
        unique case (r_state)
          IDLE: begin
            if (w_scan == SINGLE) begin
              r_cand <= w_pos_nxt;
              if (DEBOUNCE == 1) begin
                r_key_val   <= w_dec_val;
                r_key_valid <= 1'b1;
                r_key_down  <= 1'b1;
                r_cnt       <= '0;
                r_state     <= PRESSED;
              end else begin
                r_cnt   <= CW'(1);
                r_state <= DEB_PRESS;
              end
            end
          end
          DEB_PRESS: begin
            if (w_scan == SINGLE) begin
              if (w_pos_nxt == r_cand) begin
                if (w_cnt_done) begin
                  r_key_val   <= w_dec_val;
                  r_key_valid <= 1'b1;
                  r_key_down  <= 1'b1;
                  r_cnt       <= '0;
                  r_state     <= PRESSED;
                end else begin
                  r_cnt <= w_cnt_inc;
                end
              end else begin
                r_cand <= w_pos_nxt;
                r_cnt  <= CW'(1);
              end
            end else begin
              r_cnt   <= '0;
              r_state <= IDLE;
            end
          end
          PRESSED: begin
            if (w_scan == NONE) begin
              if (DEBOUNCE == 1) begin
                r_key_down <= 1'b0;
                r_cnt      <= '0;
                r_state    <= IDLE;
              end else begin
                r_cnt   <= CW'(1);
                r_state <= DEB_RELEASE;
              end
            end
          end
          DEB_RELEASE: begin
            if (w_scan == NONE) begin
              if (w_cnt_done) begin
                r_key_down <= 1'b0;
                r_cnt      <= '0;
                r_state    <= IDLE;
              end else begin
                r_cnt <= w_cnt_inc;
              end
            end else begin
              r_cnt   <= '0;
              r_state <= PRESSED;
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

endmodule
